cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Generalises the 2-bit CLA cell to WIDTH bits: operands are split into GROUP-bit lookahead groups, with one pipeline register per group so that carry ripples between groups across clock edges. The block accepts one operation per cycle through a valid/ready handshake and returns sum, carry-out and signed overflow after a fixed latency. It sits between operand sources (register file / test driver) and result consumers in the datapath.

## Interface
- WIDTH, 8, operand and sum width in bits; must be a multiple of GROUP.
- GROUP, 2, bits per lookahead group; legal values 1, 2, 4.
- STAGES (localparam), WIDTH/GROUP, pipeline depth in cycles.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operation present on a, b, ci, sub.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = A+B+ci, 1 = A−B (A + ~B + 1).
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Group k (k = 0..STAGES−1) covers bits [k*GROUP +: GROUP]. Within a group, generate g_i = a_i&b'_i, propagate p_i = a_i^b'_i; carries are computed by lookahead from the group carry-in (not rippled); sum_i = p_i ^ c_i. Here b' = sub ? ~b : b, and the group-0 carry-in = sub ? 1 : ci.
- Stage k register captures: sum bits of groups 0..k, carry out of group k, carry into the MSB (final stage only), the still-unused upper bits of a and b', and a valid bit.
- Operand skew is internal: the upper operand bits travel with the pipeline, so the caller presents the full-width a/b in a single cycle.
- The final stage drives s, cout and ovf directly from registers, with no output logic after the flops.
- Advance condition: adv = out_ready | ~out_valid. in_ready = adv. When adv=1, every stage loads from its predecessor and stage 0 loads from the inputs (valid = in_valid). When adv=0, the whole pipe holds. Bubbles are not compressed.
- An accept is a cycle with in_valid & in_ready. A result transfer is a cycle with out_valid & out_ready.
- Reset (synchronous, rst=1 at a clock edge) clears every stage valid bit and data register. In-flight operations are discarded and never emerge. Reset values: out_valid=0, s=0, cout=0, ovf=0. in_ready=1 whenever out_valid=0, including during reset.

## Timing
- Latency: an accept at edge t produces out_valid=1 with its result after edge t+STAGES−1, i.e. visible during the STAGES-th cycle after acceptance when there are no stalls. WIDTH=8, GROUP=2 gives 4 cycles.
- Throughput: 1 operation/cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 holds s/cout/ovf stable and forces in_ready=0 in the same cycle (combinational). Input values are ignored while in_ready=0.
- Simultaneous transfer and accept in one cycle is legal. No result is duplicated or lost.
- rst asserted together with in_valid: the input is dropped, and out_valid=0 on the next cycle.
- GROUP=WIDTH degenerates to a single-stage registered CLA with latency 1.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 → out_valid, s, cout and ovf all 0. No result ever emerges for inputs presented during reset.
- Add, WIDTH=8, GROUP=2: a=FF, b=01, ci=0, sub=0 → 4 cycles later s=00, cout=1, ovf=0. Also a=7F, b=01 → s=80, cout=0, ovf=1. Also a=00, b=00, ci=1 → s=01.
- Subtract: a=05, b=07, sub=1, ci=1 (ignored) → s=FE, cout=0, ovf=0. Also a=80, b=01 → s=7F, cout=1, ovf=1.
- Streaming: 16 back-to-back random operations with out_ready=1 → results appear in order on 16 consecutive cycles, with the first one 4 cycles after the first accept, all matching the reference model.
- Backpressure: drop out_ready for 3 cycles while results are in flight → in_ready=0 and outputs stable during the stall. After release, all results arrive in order with no loss or duplication.
- Mid-flight reset and parameter sweep: reset with 3 operations in flight → none emerge. Repeat a random check for (WIDTH, GROUP) = (8,1), (16,4), (4,4) against a behavioural A±B model.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor, one lookahead group per stage
module cla_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int GROUP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;

  // Lookahead add of one group: returns {carry into group MSB, group carry out, group sum}.
  // Every carry is a flat sum-of-products of g/p and the group carry-in, never rippled.
  function automatic logic [GROUP+1:0] group_add(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      t = cin;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // Per-stage registers: accumulated sum bits, group carry out, operands travelling
  // alongside so the upper groups see the operand pair issued with them.
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] sum_n [STAGES];
  logic             c_n   [STAGES];
  logic [GROUP+1:0] grp   [STAGES];
  logic             ovf_n;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic             adv;
  logic             unused_operands;

  assign b_eff = sub ? ~b : b;
  assign cin0  = sub | ci;

  assign out_valid = v_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // Operands held in the last stage have no further group to feed.
  assign unused_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

  // Next-state of each stage: add its own group on top of the predecessor's partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      grp[k]   = '0;
      sum_n[k] = '0;
      c_n[k]   = 1'b0;
    end
    grp[0]                = group_add(a[0 +: GROUP], b_eff[0 +: GROUP], cin0);
    sum_n[0][0 +: GROUP]  = grp[0][GROUP-1:0];
    c_n[0]                = grp[0][GROUP];
    for (int k = 1; k < STAGES; k++) begin
      grp[k]                   = group_add(a_q[k-1][k*GROUP +: GROUP],
                                           b_q[k-1][k*GROUP +: GROUP], c_q[k-1]);
      sum_n[k]                 = sum_q[k-1];
      sum_n[k][k*GROUP +: GROUP] = grp[k][GROUP-1:0];
      c_n[k]                   = grp[k][GROUP];
    end
    ovf_n = grp[STAGES-1][GROUP+1] ^ grp[STAGES-1][GROUP];
  end

  // Whole pipe advances together or holds together; reset empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0]   <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b_eff;
      sum_q[0] <= sum_n[0];
      c_q[0]   <= c_n[0];
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        sum_q[k] <= sum_n[k];
        c_q[k]   <= c_n[k];
      end
      ovf_q <= ovf_n;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - scoreboard bench for cla_pipe_adder over four (WIDTH, GROUP) builds
module tb_cla_pipe_adder;

  localparam int ND = 4;
  localparam int WS [ND] = '{8, 8, 16, 4};
  localparam int GS [ND] = '{2, 1, 4, 4};

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic        ci;
  logic        sub;
  logic        ordy;

  logic        ir_d [ND];
  logic        ov_d [ND];
  logic        co_d [ND];
  logic        of_d [ND];
  logic [15:0] s_d  [ND];

  exp_t        sb [ND][$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        chk_lat = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: plain integer A+B+ci or A-B, signed overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic sb_i);
    exp_t        r;
    logic [16:0] m;
    logic [16:0] full;
    logic [15:0] xx;
    logic [15:0] yy;
    m      = (17'd1 << w) - 17'd1;
    xx     = x & m[15:0];
    yy     = (sb_i ? ~y : y) & m[15:0];
    full   = {1'b0, xx} + {1'b0, yy} + ((sb_i || c) ? 17'd1 : 17'd0);
    r.s    = full[15:0] & m[15:0];
    r.c    = full[w];
    r.o    = (xx[w-1] == yy[w-1]) && (r.s[w-1] != xx[w-1]);
    r.cyc  = cyc;
    return r;
  endfunction

  for (genvar d = 0; d < ND; d++) begin : g_dut
    localparam int W = WS[d];
    localparam int G = GS[d];
    logic [W-1:0] s_l;
    exp_t         e;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv),
      .in_ready (ir_d[d]),
      .a        (a_bus[W-1:0]),
      .b        (b_bus[W-1:0]),
      .ci       (ci),
      .sub      (sub),
      .out_valid(ov_d[d]),
      .out_ready(ordy),
      .s        (s_l),
      .cout     (co_d[d]),
      .ovf      (of_d[d])
    );

    assign s_d[d] = 16'(s_l);

    // Monitor: every result transfer pops the oldest expected result of this build.
    always @(negedge clk) begin
      #2;
      if (!rst && ov_d[d] && ordy) begin
        if (sb[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut%0d_unexpected_result got=%h exp=none", d, s_l);
        end else begin
          e = sb[d].pop_front();
          check($sformatf("dut%0d_sum", d), 32'(s_d[d]), 32'(e.s));
          check($sformatf("dut%0d_cout", d), 32'(co_d[d]), 32'(e.c));
          check($sformatf("dut%0d_ovf", d), 32'(of_d[d]), 32'(e.o));
          if (chk_lat) check($sformatf("dut%0d_latency", d), 32'(cyc - e.cyc), 32'(W / G));
        end
      end
    end
  end

  // One cycle of stimulus, driven after the falling edge; accepts are scored here.
  task automatic step(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic sb_i, input logic ordy_i);
    @(negedge clk);
    rst   = r;
    iv    = v;
    a_bus = x;
    b_bus = y;
    ci    = c;
    sub   = sb_i;
    ordy  = ordy_i;
    #1;
    if (r) begin
      for (int d = 0; d < ND; d++) sb[d].delete();
    end else if (v) begin
      for (int d = 0; d < ND; d++)
        if (ir_d[d]) sb[d].push_back(model(WS[d], x, y, c, sb_i));
    end
  endtask

  task automatic rnd_op(input logic ordy_i);
    step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [15:0] held;

  initial begin
    rst = 1'b1; iv = 1'b0; a_bus = '0; b_bus = '0; ci = 1'b0; sub = 1'b0; ordy = 1'b1;

    // Reset held two cycles with live inputs: nothing accepted, outputs cleared.
    step(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("rst_out_valid", 32'(ov_d[0]), 32'd0);
    check("rst_s", 32'(s_d[0]), 32'd0);
    check("rst_cout", 32'(co_d[0]), 32'd0);
    check("rst_ovf", 32'(of_d[0]), 32'd0);
    check("rst_in_ready", 32'(ir_d[0]), 32'd1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < ND; d++) check($sformatf("post_rst_valid%0d", d), 32'(ov_d[d]), 32'd0);

    // Directed corner cases with latency checking.
    chk_lat = 1'b1;
    step(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    idle(10);

    // Streaming: 16 back-to-back operations, each must arrive exactly STAGES cycles later.
    for (int i = 0; i < 16; i++) rnd_op(1'b1);
    idle(10);

    // Backpressure: fill the 4-stage pipe, then stall three cycles.
    chk_lat = 1'b0;
    for (int i = 0; i < 4; i++) rnd_op(1'b1);
    rnd_op(1'b0);
    held = s_d[0];
    check("stall_out_valid", 32'(ov_d[0]), 32'd1);
    check("stall_in_ready0", 32'(ir_d[0]), 32'd0);
    for (int i = 1; i < 3; i++) begin
      rnd_op(1'b0);
      check($sformatf("stall_in_ready%0d", i), 32'(ir_d[0]), 32'd0);
      check($sformatf("stall_s_stable%0d", i), 32'(s_d[0]), 32'(held));
    end
    for (int i = 0; i < 4; i++) rnd_op(1'b1);
    idle(12);

    // Mid-flight reset with three operations in the pipe: none may emerge.
    for (int i = 0; i < 3; i++) rnd_op(1'b1);
    step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < ND; d++) check($sformatf("midrst_valid%0d", d), 32'(ov_d[d]), 32'd0);
    idle(12);

    // Random traffic with random consumer stalls across all four builds.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) rnd_op(($urandom_range(0, 3) != 0));
      else step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ($urandom_range(0, 3) != 0));
    end
    idle(20);

    for (int d = 0; d < ND; d++) check($sformatf("drained%0d", d), 32'(sb[d].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
